seven_seg_capture: RTL
======================

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: consecutive cycles a digit select must hold before its segments are sampled (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port seg  input  [0:6]  multiplexed segment bus, active-low, seg[0]=a … seg[6]=g.
REQ-005 SHALL have port digit  input  [7:0]  anode selects, active-low; digit[0]=ones, [1]=tens, [2]=hundreds, [3]=thousands.
REQ-006 SHALL have ports ones, tens, hundreds, thousands  output  [7:0] each  captured BCD value in bits [3:0]; bits [7:4] always 0.
REQ-007 SHALL have port frame_done  output  1  one-cycle pulse when all four outputs update.
REQ-008 SHALL have port err  output  1  one-cycle pulse on an undecodable segment pattern.

Function
REQ-009 SHALL register seg and digit once on input; all decisions use the registered copies.
REQ-010 SHALL treat a select as valid only when exactly one of digit[3:0] is 0 and digit[7:4] is all 1; every other value is "no select".
REQ-011 SHALL run a 3-state FSM: IDLE (no valid select), SETTLE (valid select, counting), HOLD (digit sampled, waiting for a select change).
REQ-012 IDLE->SETTLE when a valid select appears; stability counter loads 1.
REQ-013 In SETTLE, the counter SHALL increment each cycle the registered select is unchanged; a change to another valid select SHALL restart SETTLE with count 1; no select SHALL go to IDLE.
REQ-014 On the cycle the count equals SETTLE_CYCLES, the registered seg SHALL be decoded and written into that digit's shadow register on that edge; FSM->HOLD.
REQ-015 HOLD->SETTLE (count 1) on a different valid select; HOLD->IDLE on no select; unchanged select stays in HOLD with no resample.
REQ-016 Decode (active-low, g..a order seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 Any other pattern SHALL pulse err for one cycle on the cycle after the sample edge, SHALL NOT write the shadow, and SHALL NOT set that digit's frame-mask bit.
REQ-018 A successful sample SHALL set the digit's bit in a 4-bit frame mask; resampling an already-set digit SHALL overwrite its shadow without other effect.
REQ-019 When the mask reaches 4'b1111, on the next edge all four outputs SHALL load from shadows simultaneously, frame_done SHALL pulse for one cycle, and the mask SHALL clear.
REQ-020 Outputs SHALL change only on frame_done edges; a frame SHALL never mix old and new values.
REQ-021 If mask completion and a new sample occur on the same edge, the new sample SHALL be written to its shadow and SHALL set its mask bit after the clear.

Reset
REQ-022 While rst=0: FSM=IDLE, counter=0, mask=0, shadows=0, input registers=all 1 (blank), outputs=0, frame_done=0, err=0.
REQ-023 Reset asserted mid-SETTLE or mid-frame SHALL discard partial captures; first frame_done after release needs four fresh samples.

Structure
REQ-024 Shared package SHALL hold the FSM state encoding, the ten segment patterns, and digit-index constants (ONES=0..THOUSANDS=3).
REQ-025 Pattern-to-BCD decode SHALL be one combinational sub-module, seg_decode (7-bit in, 4-bit value + valid out).

Verification
REQ-026 Scan digits 0..3 each held 8 cycles with patterns for 4,3,2,1 -> one frame_done; thousands=4? no: ones=4, tens=3, hundreds=2, thousands=1; err never pulses.
REQ-027 Hold digit[0] low for SETTLE_CYCLES-1 cycles then switch -> no sample, mask unchanged, no frame_done.
REQ-028 Present seg=1111111 (blank) on tens during a scan -> err pulses once, frame_done withheld until tens is resent as valid digit 7, then tens=7.
REQ-029 Drive digit=8'b11111100 (two selects) for 20 cycles -> FSM stays IDLE, no sample, no err.
REQ-030 Assert rst after three digits captured, release, scan full frame of 9,9,9,9 -> exactly one frame_done, all outputs 9; no stale values before it.
REQ-031 Continuous scan 0..3 with changing values -> outputs update only at frame_done; frame_done spacing = 4 digit slots.

Source files
------------

// File: rtl/seven_seg_capture_pkg.sv
// Shared constants for the seven-segment display capture block: FSM encoding,
// digit indices and the active-low segment patterns for BCD 0..9 (g..a order).
package seven_seg_capture_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [1:0] ONES      = 2'd0;
  localparam logic [1:0] TENS      = 2'd1;
  localparam logic [1:0] HUNDREDS  = 2'd2;
  localparam logic [1:0] THOUSANDS = 2'd3;

  localparam logic [6:0] SEG_PATTERNS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // The segment bus is declared [0:6] (a..g); patterns are held as [6:0] (g..a).
  function automatic logic [6:0] to_gfedcba(input logic [0:6] bus);
    logic [6:0] p;
    for (int unsigned i = 0; i < 7; i++) p[i] = bus[i];
    return p;
  endfunction

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational active-low segment pattern to BCD decoder; valid is low for
// any pattern that is not one of the ten digit glyphs.
module seg_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    value = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        value = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit seven-segment display: waits for each digit
// select to settle, decodes its segments and publishes whole frames atomically.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] seg,
  input  logic [7:0] digit,
  output logic [7:0] ones,
  output logic [7:0] tens,
  output logic [7:0] hundreds,
  output logic [7:0] thousands,
  output logic       frame_done,
  output logic       err
);

  logic [0:6] seg_r;
  logic [7:0] digit_r;
  logic [1:0] state, state_next;
  logic [7:0] count, count_next;
  logic [1:0] cur_idx;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic       sample;
  logic [3:0] mask, mask_next;
  logic [3:0] shadow  [4];
  logic [3:0] out_val [4];
  logic [6:0] seg_pattern;
  logic [3:0] dec_value;
  logic       dec_valid;

  assign seg_pattern = to_gfedcba(seg_r);

  seg_decode u_decode (
    .pattern (seg_pattern),
    .value   (dec_value),
    .valid   (dec_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = ONES;
    if (digit_r[7:4] == 4'hF) begin
      unique case (digit_r[3:0])
        4'b1110: begin sel_valid = 1'b1; sel_idx = ONES;      end
        4'b1101: begin sel_valid = 1'b1; sel_idx = TENS;      end
        4'b1011: begin sel_valid = 1'b1; sel_idx = HUNDREDS;  end
        4'b0111: begin sel_valid = 1'b1; sel_idx = THOUSANDS; end
        default: begin sel_valid = 1'b0; sel_idx = ONES;      end
      endcase
    end
  end

  // count holds the number of consecutive cycles the current select has been seen
  always_comb begin
    state_next = state;
    count_next = count;
    sample     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_next = ST_SETTLE;
          count_next = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!sel_valid) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (sel_idx != cur_idx) begin
          count_next = 8'd1;
        end else if (count == SETTLE_CYCLES[7:0] - 8'd1) begin
          sample     = 1'b1;
          state_next = ST_HOLD;
          count_next = count + 8'd1;
        end else begin
          count_next = count + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!sel_valid) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (sel_idx != cur_idx) begin
          state_next = ST_SETTLE;
          count_next = 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // A completed frame clears first so a same-edge sample survives into the next frame.
  always_comb begin
    mask_next = (mask == 4'hF) ? '0 : mask;
    if (sample && dec_valid) mask_next[cur_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_r      <= '1;
      digit_r    <= '1;
      state      <= ST_IDLE;
      count      <= '0;
      cur_idx    <= ONES;
      mask       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i]  <= '0;
        out_val[i] <= '0;
      end
    end else begin
      seg_r      <= seg;
      digit_r    <= digit;
      state      <= state_next;
      count      <= count_next;
      mask       <= mask_next;
      frame_done <= (mask == 4'hF);
      err        <= sample && !dec_valid;
      if (sel_valid) cur_idx <= sel_idx;
      if (sample && dec_valid) shadow[cur_idx] <= dec_value;
      if (mask == 4'hF) begin
        for (int unsigned i = 0; i < 4; i++) out_val[i] <= shadow[i];
      end
    end
  end

  assign ones      = {4'h0, out_val[ONES]};
  assign tens      = {4'h0, out_val[TENS]};
  assign hundreds  = {4'h0, out_val[HUNDREDS]};
  assign thousands = {4'h0, out_val[THOUSANDS]};

endmodule
